// File: rtl/video_ula_serializer.sv
// BBC Video ULA pixel serializer: char clock, byte shifter, palette, flash, cursor.
// Define VIDEO_ULA_CURSOR_EN to build the hardware cursor sequencer and XOR mask.
module video_ula_serializer (
  input  logic       PIXELCLK,
  input  logic       nRESET,
  input  logic       nCS,
  input  logic       A0,
  input  logic [7:0] data_bus,
  input  logic [7:0] framestore_data,
  input  logic       display_en,
  input  logic       cursor,
  output logic       crtc_clken,
  output logic       R,
  output logic       G,
  output logic       B
);

  logic [7:0] ctrl_q;
  logic [3:0] pal_q [16];
  logic [3:0] cnt_q;
  logic [7:0] sr_q, sr_d;
  logic       blank_q;
  logic [2:0] rgb_q, rgb_d;
  logic       shift_en;
  logic [3:0] lcol;
  logic [3:0] pent;
  logic [2:0] colour;
  logic [2:0] cur_mask;

  assign crtc_clken = ctrl_q[4] ? (cnt_q[2:0] == 3'd7)
                                : (cnt_q == 4'd15);

  always_comb begin
    shift_en = 1'b0;
    unique case (ctrl_q[3:2])
      2'b11:   shift_en = 1'b1;
      2'b10:   shift_en = cnt_q[0];
      2'b01:   shift_en = (cnt_q[1:0] == 2'd3);
      default: shift_en = (cnt_q[2:0] == 3'd7);
    endcase
  end

  always_comb begin
    sr_d = sr_q;
    if (crtc_clken)
      sr_d = display_en ? framestore_data : 8'h00;
    else if (shift_en)
      sr_d = {sr_q[6:0], 1'b1};
  end

  // Stored nibble is inverted RGB; bit 3 flips it again when flashing.
  assign lcol   = {sr_q[7], sr_q[5], sr_q[3], sr_q[1]};
  assign pent   = pal_q[lcol];
  assign colour = pent[2:0] ^ 3'b111 ^ {3{pent[3] & ctrl_q[0]}};
  assign rgb_d  = (blank_q ? 3'b000 : colour) ^ cur_mask;

  always_ff @(posedge PIXELCLK) begin
    if (!nRESET) begin
      ctrl_q  <= 8'h00;
      cnt_q   <= 4'd0;
      sr_q    <= 8'h00;
      blank_q <= 1'b1;
      rgb_q   <= 3'b000;
      for (int i = 0; i < 16; i++)
        pal_q[i] <= 4'd0;
    end else begin
      cnt_q <= cnt_q + 4'd1;
      sr_q  <= sr_d;
      rgb_q <= rgb_d;
      if (crtc_clken)
        blank_q <= ~display_en;
      if (!nCS) begin
        if (A0)
          pal_q[data_bus[7:4]] <= data_bus[3:0];
        else
          ctrl_q <= data_bus;
      end
    end
  end

`ifdef VIDEO_ULA_CURSOR_EN
  logic       cur_act_q;
  logic [1:0] cur_seg_q;

  always_ff @(posedge PIXELCLK) begin
    if (!nRESET) begin
      cur_act_q <= 1'b0;
      cur_seg_q <= 2'd0;
    end else if (crtc_clken) begin
      if (cursor) begin
        cur_act_q <= 1'b1;
        cur_seg_q <= 2'd0;
      end else if (cur_act_q) begin
        if (cur_seg_q == 2'd3)
          cur_act_q <= 1'b0;
        cur_seg_q <= cur_seg_q + 2'd1;
      end
    end
  end

  always_comb begin
    cur_mask = 3'b000;
    if (cur_act_q) begin
      unique case (cur_seg_q)
        2'd0:    cur_mask = {3{ctrl_q[7]}};
        2'd1:    cur_mask = {3{ctrl_q[6]}};
        default: cur_mask = {3{ctrl_q[5]}};
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ctrl_q[1];
`else
  assign cur_mask = 3'b000;

  logic unused_ok;
  assign unused_ok = &{1'b0, cursor, ctrl_q[7:5], ctrl_q[1]};
`endif

  assign {B, G, R} = rgb_q;

endmodule
